// File: rtl/ps2_ascii_decoder.sv
`default_nettype none
// ============================================================================
// Module  : ps2_ascii_decoder
// Brief   : PS/2 Set-2 scan codes to ASCII with modifiers, repeat filter, FIFO
// Revision: 1.0 - initial release
// ============================================================================
module ps2_ascii_decoder #(
    parameter int FIFO_DEPTH      = 8,
    parameter int CNT_W           = 8,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             code_valid,
    input  logic [7:0]       code,
    input  logic             out_ready,
    output logic             ascii_valid,
    output logic [7:0]       ascii,
    output logic             shift_active,
    output logic             ctrl_active,
    output logic             caps_lock,
    output logic             overflow,
    output logic [CNT_W-1:0] key_count
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic SUPPRESS = (SUPPRESS_REPEAT != 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    // Two-flop reset synchronizer: assert immediately, release on a clock edge.
    logic [1:0] rst_pipe;
    logic       rst_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_s = rst_pipe[1];

    function automatic logic [7:0] translate(input logic [7:0] sc, input logic shift,
                                             input logic ctrl, input logic caps);
        logic [7:0] letter;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] fixed;
        logic [7:0] res;
        letter = 8'h00;
        lo     = 8'h00;
        hi     = 8'h00;
        fixed  = 8'h00;
        case (sc)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            8'h16: begin lo = "1";  hi = "!"; end
            8'h1E: begin lo = "2";  hi = "@"; end
            8'h26: begin lo = "3";  hi = "#"; end
            8'h25: begin lo = "4";  hi = "$"; end
            8'h2E: begin lo = "5";  hi = "%"; end
            8'h36: begin lo = "6";  hi = "^"; end
            8'h3D: begin lo = "7";  hi = "&"; end
            8'h3E: begin lo = "8";  hi = "*"; end
            8'h46: begin lo = "9";  hi = "("; end
            8'h45: begin lo = "0";  hi = ")"; end
            8'h4E: begin lo = "-";  hi = "_"; end
            8'h55: begin lo = "=";  hi = "+"; end
            8'h54: begin lo = "[";  hi = "{"; end
            8'h5B: begin lo = "]";  hi = "}"; end
            8'h5D: begin lo = 8'h5C; hi = "|"; end
            8'h4C: begin lo = ";";  hi = ":"; end
            8'h52: begin lo = 8'h27; hi = 8'h22; end
            8'h41: begin lo = ",";  hi = "<"; end
            8'h49: begin lo = ".";  hi = ">"; end
            8'h4A: begin lo = "/";  hi = "?"; end
            8'h0E: begin lo = 8'h60; hi = "~"; end
            8'h70: fixed = "0";  8'h69: fixed = "1";  8'h72: fixed = "2";
            8'h7A: fixed = "3";  8'h6B: fixed = "4";  8'h73: fixed = "5";
            8'h74: fixed = "6";  8'h6C: fixed = "7";  8'h75: fixed = "8";
            8'h7D: fixed = "9";  8'h71: fixed = ".";  8'h79: fixed = "+";
            8'h7B: fixed = "-";  8'h7C: fixed = "*";
            8'h66: fixed = 8'h08; 8'h0D: fixed = 8'h09; 8'h5A: fixed = 8'h0D;
            8'h76: fixed = 8'h1B; 8'h29: fixed = 8'h20;
            default: fixed = 8'h00;
        endcase
        if (letter != 8'h00) begin
            if (ctrl)              res = letter - 8'h60;
            else if (shift ^ caps) res = letter - 8'h20;
            else                   res = letter;
        end else if (lo != 8'h00) begin
            res = (shift && !ctrl) ? hi : lo;
        end else begin
            res = fixed;
        end
        return res;
    endfunction

    state_t     state, state_nxt;
    logic       lshift, rshift, lctrl, rctrl, caps;
    logic       lshift_nxt, rshift_nxt, lctrl_nxt, rctrl_nxt, caps_nxt;
    logic [7:0] held, held_nxt;
    logic       push;
    logic [7:0] push_data;
    logic [7:0] tr;

    assign shift_active = lshift | rshift;
    assign ctrl_active  = lctrl | rctrl;
    assign caps_lock    = caps;
    assign tr           = translate(code, shift_active, ctrl_active, caps);

    always_comb begin
        state_nxt  = state;
        lshift_nxt = lshift;
        rshift_nxt = rshift;
        lctrl_nxt  = lctrl;
        rctrl_nxt  = rctrl;
        caps_nxt   = caps;
        held_nxt   = held;
        push       = 1'b0;
        push_data  = 8'h00;
        if (code_valid) begin
            case (state)
                S_IDLE: begin
                    if (code == 8'hF0)      state_nxt = S_BRK;
                    else if (code == 8'hE0) state_nxt = S_EXT;
                    else begin
                        held_nxt = code;
                        case (code)
                            8'h12: lshift_nxt = 1'b1;
                            8'h59: rshift_nxt = 1'b1;
                            8'h14: lctrl_nxt  = 1'b1;
                            8'h58: if (held != 8'h58) caps_nxt = ~caps;
                            default: begin
                                push_data = tr;
                                push      = (tr != 8'h00) && !(SUPPRESS && code == held);
                            end
                        endcase
                    end
                end
                S_EXT: begin
                    if (code == 8'hF0) state_nxt = S_EXT_BRK;
                    else begin
                        state_nxt = S_IDLE;
                        case (code)
                            8'h14: rctrl_nxt = 1'b1;
                            8'h4A: begin push = 1'b1; push_data = 8'h2F; end
                            8'h5A: begin push = 1'b1; push_data = 8'h0D; end
                            default: ;
                        endcase
                    end
                end
                S_BRK: begin
                    if (code != 8'hF0 && code != 8'hE0) begin
                        state_nxt = S_IDLE;
                        case (code)
                            8'h12: lshift_nxt = 1'b0;
                            8'h59: rshift_nxt = 1'b0;
                            8'h14: lctrl_nxt  = 1'b0;
                            default: ;
                        endcase
                        if (code == held) held_nxt = 8'h00;
                    end
                end
                default: begin
                    if (code != 8'hE0) begin
                        state_nxt = S_IDLE;
                        if (code == 8'h14) rctrl_nxt = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            state  <= S_IDLE;
            lshift <= 1'b0;
            rshift <= 1'b0;
            lctrl  <= 1'b0;
            rctrl  <= 1'b0;
            caps   <= 1'b0;
            held   <= 8'h00;
        end else begin
            state  <= state_nxt;
            lshift <= lshift_nxt;
            rshift <= rshift_nxt;
            lctrl  <= lctrl_nxt;
            rctrl  <= rctrl_nxt;
            caps   <= caps_nxt;
            held   <= held_nxt;
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [7:0]      mem [FIFO_DEPTH];
    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic            full, pop, accept;

    assign ascii_valid = (wr_ptr != rd_ptr);
    assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                         (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign pop         = ascii_valid && out_ready;
    assign accept      = push && (!full || pop);
    assign ascii       = ascii_valid ? mem[rd_ptr[ADDR_W-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            key_count <= '0;
        end else begin
            overflow <= push && full && !pop;
            if (accept) begin
                wr_ptr    <= wr_ptr + PTR_ONE;
                key_count <= key_count + CNT_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_ascii_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_ascii_decoder
// Brief   : table-driven and directed checks of ps2_ascii_decoder
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_ascii_decoder;

    logic       clk;
    logic       rst_n;
    logic       code_valid;
    logic [7:0] code;
    logic       out_ready;
    logic       ascii_valid;
    logic [7:0] ascii;
    logic       shift_active;
    logic       ctrl_active;
    logic       caps_lock;
    logic       overflow;
    logic [7:0] key_count;

    int checks = 0;
    int errors = 0;

    ps2_ascii_decoder #(
        .FIFO_DEPTH     (8),
        .CNT_W          (8),
        .SUPPRESS_REPEAT(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .code_valid  (code_valid),
        .code        (code),
        .out_ready   (out_ready),
        .ascii_valid (ascii_valid),
        .ascii       (ascii),
        .shift_active(shift_active),
        .ctrl_active (ctrl_active),
        .caps_lock   (caps_lock),
        .overflow    (overflow),
        .key_count   (key_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] code;
        logic       exp_valid;
        logic [7:0] exp_ascii;
        logic       exp_shift;
        logic       exp_ctrl;
        logic       exp_caps;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] c, input logic v, input logic [7:0] a,
                       input logic s, input logic ct, input logic cp);
        vec_t r;
        r.code = c; r.exp_valid = v; r.exp_ascii = a;
        r.exp_shift = s; r.exp_ctrl = ct; r.exp_caps = cp;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        code       = c;
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    logic [7:0] exp_kc;
    logic [7:0] ovf_codes [11];
    logic [7:0] drain_exp [8];

    initial begin
        rst_n      = 1'b0;
        code_valid = 1'b0;
        code       = 8'h00;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();

        check("reset_state", {ascii_valid, ascii, shift_active, ctrl_active, caps_lock,
                              overflow, key_count}, 32'h0);

        // code, valid, ascii, shift, ctrl, caps (state sampled after the byte)
        add(8'h1C, 1, 8'h61, 0, 0, 0); add(8'hF0, 0, 0, 0, 0, 0); add(8'h1C, 0, 0, 0, 0, 0);
        add(8'h12, 0, 0, 1, 0, 0); add(8'h1C, 1, 8'h41, 1, 0, 0);
        add(8'hF0, 0, 0, 1, 0, 0); add(8'h1C, 0, 0, 1, 0, 0);
        add(8'hF0, 0, 0, 1, 0, 0); add(8'h12, 0, 0, 0, 0, 0);
        add(8'h1C, 1, 8'h61, 0, 0, 0); add(8'hF0, 0, 0, 0, 0, 0); add(8'h1C, 0, 0, 0, 0, 0);
        add(8'h58, 0, 0, 0, 0, 1); add(8'hF0, 0, 0, 0, 0, 1); add(8'h58, 0, 0, 0, 0, 1);
        add(8'h1C, 1, 8'h41, 0, 0, 1); add(8'h12, 0, 0, 1, 0, 1);
        add(8'h1C, 1, 8'h61, 1, 0, 1); add(8'h16, 1, 8'h21, 1, 0, 1);
        add(8'hF0, 0, 0, 1, 0, 1); add(8'h16, 0, 0, 1, 0, 1);
        add(8'hF0, 0, 0, 1, 0, 1); add(8'h12, 0, 0, 0, 0, 1);
        add(8'hF0, 0, 0, 0, 0, 1); add(8'h1C, 0, 0, 0, 0, 1);
        add(8'h58, 0, 0, 0, 0, 0); add(8'h58, 0, 0, 0, 0, 0);
        add(8'hF0, 0, 0, 0, 0, 0); add(8'h58, 0, 0, 0, 0, 0);
        // typematic repeats
        add(8'h1C, 1, 8'h61, 0, 0, 0); add(8'h1C, 0, 0, 0, 0, 0);
        add(8'h1C, 0, 0, 0, 0, 0); add(8'h1C, 0, 0, 0, 0, 0);
        add(8'hF0, 0, 0, 0, 0, 0); add(8'h1C, 0, 0, 0, 0, 0);
        add(8'h1C, 1, 8'h61, 0, 0, 0); add(8'hF0, 0, 0, 0, 0, 0); add(8'h1C, 0, 0, 0, 0, 0);
        // Ctrl: letter control codes, shift ignored on digits
        add(8'h14, 0, 0, 0, 1, 0); add(8'h21, 1, 8'h03, 0, 1, 0);
        add(8'hF0, 0, 0, 0, 1, 0); add(8'h21, 0, 0, 0, 1, 0);
        add(8'h12, 0, 0, 1, 1, 0); add(8'h16, 1, 8'h31, 1, 1, 0);
        add(8'hF0, 0, 0, 1, 1, 0); add(8'h16, 0, 0, 1, 1, 0);
        add(8'hF0, 0, 0, 1, 1, 0); add(8'h14, 0, 0, 1, 0, 0);
        // keypad ignores shift, slash shifts to '?'
        add(8'h70, 1, 8'h30, 1, 0, 0); add(8'hF0, 0, 0, 1, 0, 0); add(8'h70, 0, 0, 1, 0, 0);
        add(8'h4A, 1, 8'h3F, 1, 0, 0); add(8'hF0, 0, 0, 1, 0, 0); add(8'h4A, 0, 0, 1, 0, 0);
        add(8'hF0, 0, 0, 1, 0, 0); add(8'h12, 0, 0, 0, 0, 0);
        add(8'h7C, 1, 8'h2A, 0, 0, 0); add(8'hF0, 0, 0, 0, 0, 0); add(8'h7C, 0, 0, 0, 0, 0);
        // extended keys
        add(8'hE0, 0, 0, 0, 0, 0); add(8'h14, 0, 0, 0, 1, 0);
        add(8'hE0, 0, 0, 0, 1, 0); add(8'hF0, 0, 0, 0, 1, 0); add(8'h14, 0, 0, 0, 0, 0);
        add(8'hE0, 0, 0, 0, 0, 0); add(8'h5A, 1, 8'h0D, 0, 0, 0);
        add(8'hE0, 0, 0, 0, 0, 0); add(8'hF0, 0, 0, 0, 0, 0); add(8'h5A, 0, 0, 0, 0, 0);
        add(8'hE0, 0, 0, 0, 0, 0); add(8'h4A, 1, 8'h2F, 0, 0, 0);
        // E0 inside a break is ignored
        add(8'hF0, 0, 0, 0, 0, 0); add(8'hE0, 0, 0, 0, 0, 0); add(8'h1C, 0, 0, 0, 0, 0);
        add(8'h1C, 1, 8'h61, 0, 0, 0); add(8'hF0, 0, 0, 0, 0, 0); add(8'h1C, 0, 0, 0, 0, 0);
        // unmapped and control keys
        add(8'h07, 0, 0, 0, 0, 0); add(8'hF0, 0, 0, 0, 0, 0); add(8'h07, 0, 0, 0, 0, 0);
        add(8'h29, 1, 8'h20, 0, 0, 0); add(8'h66, 1, 8'h08, 0, 0, 0);

        exp_kc = 8'h00;
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].code);
            check($sformatf("vec%0d_code%h", i, vecs[i].code),
                  {ascii_valid, ascii, shift_active, ctrl_active, caps_lock},
                  {vecs[i].exp_valid, vecs[i].exp_ascii, vecs[i].exp_shift,
                   vecs[i].exp_ctrl, vecs[i].exp_caps});
            if (vecs[i].exp_valid) exp_kc = exp_kc + 8'h01;
            if (ascii_valid) begin
                pop_one();
                check($sformatf("vec%0d_drained", i), {31'h0, ascii_valid}, 32'h0);
            end
        end
        check("key_count_table", {24'h0, key_count}, {24'h0, exp_kc});

        // overflow: ten distinct makes into an 8-deep FIFO with no consumer
        do_reset();
        ovf_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                      8'h43, 8'h3B, 8'h42};
        for (int i = 0; i < 10; i++) begin
            send(ovf_codes[i]);
            check($sformatf("ovf_pulse%0d", i), {31'h0, overflow}, {31'h0, (i >= 8)});
        end
        @(negedge clk);
        check("ovf_clear", {31'h0, overflow}, 32'h0);
        check("key_count_full", {24'h0, key_count}, 32'd8);

        // simultaneous push and pop while full: accepted, no overflow
        out_ready = 1'b1;
        send(ovf_codes[10]);
        out_ready = 1'b0;
        check("full_pushpop_ovf", {31'h0, overflow}, 32'h0);
        check("full_pushpop_cnt", {24'h0, key_count}, 32'd9);

        drain_exp = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h6B};
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d", i), {23'h0, ascii_valid, ascii},
                  {23'h0, 1'b1, drain_exp[i]});
            pop_one();
        end
        check("drain_empty", {31'h0, ascii_valid}, 32'h0);

        // reset in the middle of an extended prefix
        send(8'h58);
        send(8'hF0);
        send(8'h58);
        send(8'h1C);
        check("pre_reset_caps", {23'h0, caps_lock, ascii_valid, ascii}, {23'h0, 1'b1, 1'b1, 8'h41});
        send(8'hE0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_reset_state", {ascii_valid, caps_lock, key_count}, 32'h0);
        send(8'h1C);
        check("post_reset_char", {22'h0, caps_lock, ascii_valid, ascii}, {22'h0, 1'b0, 1'b1, 8'h61});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_ascii_decoder.md
Name: ps2_ascii_decoder

Overview:
Stateful PS/2 Set-2 scan-code to ASCII decoder. It sits between the PS/2 byte receiver and character consumers such as the display and terminal. It tracks make/break, E0-extended prefixes, Shift/Ctrl/CapsLock state and typematic repeats, and buffers produced characters in a parametrised FIFO with a valid/ready output handshake.

Parameters:
FIFO_DEPTH, 8, output character FIFO entries; power of 2, ≥2.
CNT_W, 8, width of accepted-character counter.
SUPPRESS_REPEAT, 1, 1 = drop typematic repeats of the held key; 0 = emit every make.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
code_valid  input  1  one-cycle strobe; code holds a received scan byte.
code  input  8  scan-code byte.
out_ready  input  1  consumer accepts head character this cycle.
ascii_valid  output  1  FIFO non-empty; ascii is valid.
ascii  output  8  FIFO head character.
shift_active  output  1  either Shift (0x12, 0x59) held.
ctrl_active  output  1  either Ctrl (0x14, E0 14) held.
caps_lock  output  1  CapsLock toggle state.
overflow  output  1  one-cycle pulse: character dropped, FIFO full.
key_count  output  CNT_W  characters written into FIFO, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync deassert internally): FSM=IDLE, FIFO empty, all outputs 0, held-key register 0.
- FSM is advanced only on code_valid. States: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
  IDLE: F0->BRK; E0->EXT; else make(code), stay.
  EXT: F0->EXT_BRK; else ext_make(code)->IDLE.
  BRK: break(code)->IDLE. EXT_BRK: ext_break(code)->IDLE.
  E0 received in BRK/EXT_BRK, or F0 received in BRK, is ignored and the state is held.
- make: 0x12/0x59 set the corresponding shift flag. 0x14 sets lctrl. 0x58 toggles caps_lock, but only when the held key ≠ 0x58, so repeats do not toggle. Any other code: translate; if the result is non-zero and it is not a suppressed repeat, push it. Held key := code.
- break: clears the shift/ctrl flag. If code == held key, held key := 0. Nothing is pushed.
- ext_make: 0x14 sets rctrl. 0x4A pushes 0x2F. 0x5A pushes 0x0D. Others are ignored. ext_break: 0x14 clears rctrl.
- Suppressed repeat: SUPPRESS_REPEAT=1 and code == held key.
- Translation (base US map, lowercase letters):
  Letters a–z: uppercase (−0x20) iff shift_active XOR caps_lock. If ctrl_active, result = 0x01..0x1A, and Ctrl takes priority.
  Top-row digits/symbols with shift: 1!2@3#4$5%6^7&8*9(0) -_ =+ [{ ]} \| ;: '" ,< .> /? `~. Shift is ignored for these when Ctrl is held.
  Keypad (0x69..0x7D, 0x70, 0x71, 0x79, 0x7B, 0x7C): fixed digits / . + - *, unaffected by modifiers.
  Control keys: BackSpace 0x08, Tab 0x09, Enter 0x0D, Esc 0x1B, Space 0x20. Unmapped codes give 0 and are not pushed.
- Latency: code_valid in cycle N pushes in cycle N. With the FIFO previously empty, ascii_valid=1 from cycle N+1.
- FIFO: pop when ascii_valid && out_ready. Push when full without a pop: character dropped, overflow=1 for one cycle, key_count unchanged. Push and pop together when full: both take effect, no overflow. Push and pop together when empty: push only. Order is strictly FIFO; pointers wrap modulo FIFO_DEPTH.
- key_count increments on each accepted push.
- Modifier outputs are registered and update the cycle after the code byte.
- Reset mid-sequence discards any pending prefix, all modifiers and buffered characters.

Test Plan:
- 1C, F0 1C -> one char 0x61; key_count=1; ascii_valid drops after one out_ready cycle.
- 12, 1C, F0 1C, F0 12, 1C -> chars 0x41 then 0x61; shift_active high between 12 and F0 12.
- 58, F0 58, 1C, 12, 1C, 16 -> caps_lock=1; chars 0x41, 0x61, 0x21.
- SUPPRESS_REPEAT=1: 1C ×4, F0 1C, 1C -> exactly two 0x61. Ctrl case: 14, 21 -> 0x03.
- FIFO_DEPTH=8, out_ready=0, ten distinct makes -> overflow pulses on the 9th and 10th; draining yields the first 8 in order; key_count=8.
- E0 5A -> 0x0D. E0 F0 5A -> nothing. E0, rst_n low 1 cycle, 1C -> 0x61 (prefix discarded, caps_lock=0).
